// File: rtl/fp_unpack_pkg.sv
// Shared constants and types for the FP adder operand unpacker.
// Holds IEEE-754 single-precision field widths, state encoding and the operand class record.
package fp_unpack_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;

    localparam logic [EXP_W-1:0] EXP_ALL_ONES = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CLASSIFY = 2'd1,
        ST_NORM     = 2'd2,
        ST_HOLD     = 2'd3
    } state_e;

    typedef struct packed {
        logic zero;
        logic denorm;
        logic inf;
        logic nan;
        logic snan;
    } op_class_t;

endpackage

// File: rtl/fp_operand_unpack_decode.sv
// Combinational field split and classification of one IEEE-754 operand.
// Produces sign, widened biased exponent, mantissa with explicit hidden bit and class flags.
module fp_class_decode #(
    parameter int EXP_W  = fp_unpack_pkg::EXP_W,
    parameter int FRAC_W = fp_unpack_pkg::FRAC_W
) (
    input  logic [EXP_W+FRAC_W:0]     op_in,
    output logic                      sign_out,
    output logic [EXP_W+1:0]          exp_out,
    output logic [FRAC_W:0]           man_out,
    output fp_unpack_pkg::op_class_t  cls_out
);

    logic [EXP_W-1:0]  exp_field_s;
    logic [FRAC_W-1:0] frac_field_s;
    logic              exp_zero_s;
    logic              exp_ones_s;
    logic              frac_zero_s;

    assign sign_out     = op_in[EXP_W+FRAC_W];
    assign exp_field_s  = op_in[EXP_W+FRAC_W-1:FRAC_W];
    assign frac_field_s = op_in[FRAC_W-1:0];
    assign exp_zero_s   = ~(|exp_field_s);
    assign exp_ones_s   = &exp_field_s;
    assign frac_zero_s  = ~(|frac_field_s);

    // Denormals start at exponent 1 so that each normalizing shift is a plain decrement.
    always_comb begin
        cls_out = '0;
        exp_out = '0;
        man_out = '0;
        if (exp_zero_s) begin
            if (frac_zero_s) begin
                cls_out.zero = 1'b1;
            end else begin
                cls_out.denorm = 1'b1;
                exp_out        = {{(EXP_W+1){1'b0}}, 1'b1};
                man_out        = {1'b0, frac_field_s};
            end
        end else if (exp_ones_s) begin
            exp_out = {2'b00, exp_field_s};
            if (frac_zero_s) begin
                cls_out.inf = 1'b1;
            end else begin
                cls_out.nan  = 1'b1;
                cls_out.snan = ~frac_field_s[FRAC_W-1];
                man_out      = {1'b0, frac_field_s};
            end
        end else begin
            exp_out = {2'b00, exp_field_s};
            man_out = {1'b1, frac_field_s};
        end
    end

endmodule

// File: rtl/fp_operand_unpack.sv
// Input-side operand unpacker for the FP adder: latch, classify, normalize denormals, hold.
// Denormals are normalized one shift per cycle so downstream always sees mantissa MSB set.
module fp_operand_unpack #(
    parameter int EXP_W  = fp_unpack_pkg::EXP_W,
    parameter int FRAC_W = fp_unpack_pkg::FRAC_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [EXP_W+FRAC_W:0]   a_in,
    input  logic [EXP_W+FRAC_W:0]   b_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    a_sign,
    output logic                    b_sign,
    output logic [EXP_W+1:0]        a_exp,
    output logic [EXP_W+1:0]        b_exp,
    output logic [FRAC_W:0]         a_man,
    output logic [FRAC_W:0]         b_man,
    output logic                    a_zero,
    output logic                    a_denorm,
    output logic                    a_inf,
    output logic                    a_nan,
    output logic                    a_snan,
    output logic                    b_zero,
    output logic                    b_denorm,
    output logic                    b_inf,
    output logic                    b_nan,
    output logic                    b_snan,
    output logic                    out_invalid
);

    import fp_unpack_pkg::*;

    localparam int OPW = EXP_W + FRAC_W + 1;
    localparam int XW  = EXP_W + 2;
    localparam int MW  = FRAC_W + 1;
    localparam logic [XW-1:0] EXP_ONE = {{(XW-1){1'b0}}, 1'b1};

    logic [1:0]     state_q, state_d;
    logic [OPW-1:0] a_raw_q, a_raw_d, b_raw_q, b_raw_d;
    logic           a_sign_q, a_sign_d, b_sign_q, b_sign_d;
    logic [XW-1:0]  a_exp_q, a_exp_d, b_exp_q, b_exp_d;
    logic [MW-1:0]  a_man_q, a_man_d, b_man_q, b_man_d;
    op_class_t      a_cls_q, a_cls_d, b_cls_q, b_cls_d;
    logic           out_valid_q, out_valid_d;
    logic           in_ready_q, in_ready_d;
    logic           out_invalid_q, out_invalid_d;

    logic           a_dec_sign_s, b_dec_sign_s;
    logic [XW-1:0]  a_dec_exp_s, b_dec_exp_s;
    logic [MW-1:0]  a_dec_man_s, b_dec_man_s;
    op_class_t      a_dec_cls_s, b_dec_cls_s;

    logic           a_shift_s, b_shift_s;
    logic [MW-1:0]  a_man_nx_s, b_man_nx_s;
    logic           a_done_s, b_done_s;

    fp_class_decode #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_dec_a (
        .op_in    (a_raw_q),
        .sign_out (a_dec_sign_s),
        .exp_out  (a_dec_exp_s),
        .man_out  (a_dec_man_s),
        .cls_out  (a_dec_cls_s)
    );

    fp_class_decode #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_dec_b (
        .op_in    (b_raw_q),
        .sign_out (b_dec_sign_s),
        .exp_out  (b_dec_exp_s),
        .man_out  (b_dec_man_s),
        .cls_out  (b_dec_cls_s)
    );

    // Completion is judged on the post-shift mantissa so HOLD follows the last shift directly.
    assign a_shift_s  = a_cls_q.denorm & ~a_man_q[MW-1];
    assign b_shift_s  = b_cls_q.denorm & ~b_man_q[MW-1];
    assign a_man_nx_s = a_shift_s ? {a_man_q[MW-2:0], 1'b0} : a_man_q;
    assign b_man_nx_s = b_shift_s ? {b_man_q[MW-2:0], 1'b0} : b_man_q;
    assign a_done_s   = ~a_cls_q.denorm | a_man_nx_s[MW-1];
    assign b_done_s   = ~b_cls_q.denorm | b_man_nx_s[MW-1];

    // Next-state and datapath register updates for the unpack FSM.
    always_comb begin
        state_d       = state_q;
        a_raw_d       = a_raw_q;
        b_raw_d       = b_raw_q;
        a_sign_d      = a_sign_q;
        b_sign_d      = b_sign_q;
        a_exp_d       = a_exp_q;
        b_exp_d       = b_exp_q;
        a_man_d       = a_man_q;
        b_man_d       = b_man_q;
        a_cls_d       = a_cls_q;
        b_cls_d       = b_cls_q;
        out_valid_d   = out_valid_q;
        in_ready_d    = in_ready_q;
        out_invalid_d = out_invalid_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_raw_d    = a_in;
                    b_raw_d    = b_in;
                    in_ready_d = 1'b0;
                    state_d    = ST_CLASSIFY;
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            ST_CLASSIFY: begin
                a_sign_d      = a_dec_sign_s;
                b_sign_d      = b_dec_sign_s;
                a_exp_d       = a_dec_exp_s;
                b_exp_d       = b_dec_exp_s;
                a_man_d       = a_dec_man_s;
                b_man_d       = b_dec_man_s;
                a_cls_d       = a_dec_cls_s;
                b_cls_d       = b_dec_cls_s;
                out_invalid_d = a_dec_cls_s.snan | b_dec_cls_s.snan;
                if (a_dec_cls_s.denorm || b_dec_cls_s.denorm) begin
                    state_d = ST_NORM;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_NORM: begin
                a_man_d = a_man_nx_s;
                b_man_d = b_man_nx_s;
                a_exp_d = a_shift_s ? (a_exp_q - EXP_ONE) : a_exp_q;
                b_exp_d = b_shift_s ? (b_exp_q - EXP_ONE) : b_exp_q;
                if (a_done_s && b_done_s) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_NORM;
                end
            end
            ST_HOLD: begin
                // The first HOLD cycle only raises out_valid; the handshake is honoured after that.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any pair in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            a_raw_q       <= '0;
            b_raw_q       <= '0;
            a_sign_q      <= 1'b0;
            b_sign_q      <= 1'b0;
            a_exp_q       <= '0;
            b_exp_q       <= '0;
            a_man_q       <= '0;
            b_man_q       <= '0;
            a_cls_q       <= '0;
            b_cls_q       <= '0;
            out_valid_q   <= 1'b0;
            in_ready_q    <= 1'b1;
            out_invalid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            a_raw_q       <= a_raw_d;
            b_raw_q       <= b_raw_d;
            a_sign_q      <= a_sign_d;
            b_sign_q      <= b_sign_d;
            a_exp_q       <= a_exp_d;
            b_exp_q       <= b_exp_d;
            a_man_q       <= a_man_d;
            b_man_q       <= b_man_d;
            a_cls_q       <= a_cls_d;
            b_cls_q       <= b_cls_d;
            out_valid_q   <= out_valid_d;
            in_ready_q    <= in_ready_d;
            out_invalid_q <= out_invalid_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_invalid = out_invalid_q;
    assign a_sign      = a_sign_q;
    assign b_sign      = b_sign_q;
    assign a_exp       = a_exp_q;
    assign b_exp       = b_exp_q;
    assign a_man       = a_man_q;
    assign b_man       = b_man_q;
    assign a_zero      = a_cls_q.zero;
    assign a_denorm    = a_cls_q.denorm;
    assign a_inf       = a_cls_q.inf;
    assign a_nan       = a_cls_q.nan;
    assign a_snan      = a_cls_q.snan;
    assign b_zero      = b_cls_q.zero;
    assign b_denorm    = b_cls_q.denorm;
    assign b_inf       = b_cls_q.inf;
    assign b_nan       = b_cls_q.nan;
    assign b_snan      = b_cls_q.snan;

endmodule

// File: tb/tb_fp_operand_unpack.sv
// Scoreboard bench for fp_operand_unpack: expected results are queued at stimulus time
// and compared, together with latency, when the unpacker presents its result.
module tb_fp_operand_unpack;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_in, b_in;
    logic        out_valid;
    logic        out_ready;
    logic        a_sign, b_sign;
    logic [9:0]  a_exp, b_exp;
    logic [23:0] a_man, b_man;
    logic        a_zero, a_denorm, a_inf, a_nan, a_snan;
    logic        b_zero, b_denorm, b_inf, b_nan, b_snan;
    logic        out_invalid;

    typedef struct {
        int          lat;
        logic        as_, bs_;
        logic [9:0]  ae, be;
        logic [23:0] am, bm;
        logic [4:0]  af, bf;
        logic        inv;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    fp_operand_unpack dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .a_sign(a_sign), .b_sign(b_sign),
        .a_exp(a_exp), .b_exp(b_exp),
        .a_man(a_man), .b_man(b_man),
        .a_zero(a_zero), .a_denorm(a_denorm), .a_inf(a_inf), .a_nan(a_nan), .a_snan(a_snan),
        .b_zero(b_zero), .b_denorm(b_denorm), .b_inf(b_inf), .b_nan(b_nan), .b_snan(b_snan),
        .out_invalid(out_invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference decode + normalization of one operand, flags ordered {zero,denorm,inf,nan,snan}.
    function automatic void model_op(input logic [31:0] x, output logic s, output logic [9:0] e,
                                     output logic [23:0] m, output logic [4:0] fl, output int sh);
        logic [7:0]  ef;
        logic [22:0] fr;
        ef = x[30:23];
        fr = x[22:0];
        s  = x[31];
        sh = 0;
        fl = 5'b00000;
        e  = 10'd0;
        m  = 24'd0;
        if (ef == 8'd0 && fr == 23'd0) begin
            fl[4] = 1'b1;
        end else if (ef == 8'd0) begin
            fl[3] = 1'b1;
            e = 10'd1;
            m = {1'b0, fr};
            while (m[23] == 1'b0) begin
                m  = m << 1;
                e  = e - 10'd1;
                sh = sh + 1;
            end
        end else if (ef == 8'hFF) begin
            e = 10'd255;
            if (fr == 23'd0) begin
                fl[2] = 1'b1;
            end else begin
                fl[1] = 1'b1;
                fl[0] = ~fr[22];
                m = {1'b0, fr};
            end
        end else begin
            e = {2'b00, ef};
            m = {1'b1, fr};
        end
    endfunction

    function automatic exp_t model_pair(input logic [31:0] a, input logic [31:0] b);
        exp_t r;
        int   sa, sb;
        model_op(a, r.as_, r.ae, r.am, r.af, sa);
        model_op(b, r.bs_, r.be, r.bm, r.bf, sb);
        r.inv = r.af[0] | r.bf[0];
        r.lat = 2 + ((sa > sb) ? sa : sb);
        return r;
    endfunction

    task automatic check_outputs(input string tag, input exp_t e);
        check_val({tag, ".a_sign"}, {31'd0, a_sign}, {31'd0, e.as_});
        check_val({tag, ".b_sign"}, {31'd0, b_sign}, {31'd0, e.bs_});
        check_val({tag, ".a_exp"}, {22'd0, a_exp}, {22'd0, e.ae});
        check_val({tag, ".b_exp"}, {22'd0, b_exp}, {22'd0, e.be});
        check_val({tag, ".a_man"}, {8'd0, a_man}, {8'd0, e.am});
        check_val({tag, ".b_man"}, {8'd0, b_man}, {8'd0, e.bm});
        check_val({tag, ".a_flags"}, {27'd0, a_zero, a_denorm, a_inf, a_nan, a_snan}, {27'd0, e.af});
        check_val({tag, ".b_flags"}, {27'd0, b_zero, b_denorm, b_inf, b_nan, b_snan}, {27'd0, e.bf});
        check_val({tag, ".invalid"}, {31'd0, out_invalid}, {31'd0, e.inv});
    endtask

    // Send one pair, measure latency, compare, optionally stall, then complete the handshake.
    task automatic run_pair(input string tag, input logic [31:0] a, input logic [31:0] b, input int stall);
        exp_t e;
        int   cyc;
        @(negedge clk);
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check_val({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        a_in = a;
        b_in = b;
        in_valid = 1'b1;
        sb_q.push_back(model_pair(a, b));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        e = sb_q.pop_front();
        check_val({tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
        check_val({tag, ".latency"}, cyc, e.lat);
        check_outputs(tag, e);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            check_val({tag, ".stall_valid"}, {31'd0, out_valid}, 32'd1);
            check_val({tag, ".stall_in_ready"}, {31'd0, in_ready}, 32'd0);
            check_outputs({tag, ".stall"}, e);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_val({tag, ".post_in_ready"}, {31'd0, in_ready}, 32'd1);
        check_val({tag, ".post_out_valid"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int          seen;
        logic [31:0] ra, rb;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = 32'd0;
        b_in      = 32'd0;
        repeat (3) @(negedge clk);
        check_val("rst.out_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst.in_ready", {31'd0, in_ready}, 32'd1);
        check_val("rst.a_exp", {22'd0, a_exp}, 32'd0);
        check_val("rst.b_man", {8'd0, b_man}, 32'd0);
        check_val("rst.flags", {22'd0, a_zero, a_denorm, a_inf, a_nan, a_snan,
                                b_zero, b_denorm, b_inf, b_nan, b_snan}, 32'd0);
        check_val("rst.invalid", {31'd0, out_invalid}, 32'd0);
        rst_n = 1'b1;

        run_pair("t1_norm", 32'h3F800000, 32'h40000000, 0);
        run_pair("t2_denorm1", 32'h00000001, 32'h3F800000, 0);
        run_pair("t3_inf_snan", 32'h7F800000, 32'h7FA00000, 0);
        run_pair("t4_zero_den", 32'h80000000, 32'h00400000, 0);
        run_pair("t5_backpress", 32'h3F800000, 32'h40000000, 5);
        run_pair("t6_after_bp", 32'hC0490FDB, 32'h00000003, 0);
        run_pair("t7_qnan_both_den", 32'h7FC00001, 32'h80012345, 0);

        for (int k = 0; k < 6; k++) begin
            ra = $urandom;
            rb = $urandom;
            case (k % 3)
                0: ra[30:23] = 8'd0;
                1: rb[30:23] = 8'hFF;
                default: rb[30:23] = 8'd0;
            endcase
            run_pair("rand", ra, rb, k % 2);
        end

        // Reset in the middle of a long normalization drops the pair.
        @(negedge clk);
        a_in = 32'h00000001;
        b_in = 32'h3F800000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("midrst.out_valid", {31'd0, out_valid}, 32'd0);
        check_val("midrst.in_ready", {31'd0, in_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check_val("midrst.no_valid", seen, 32'd0);
        check_val("midrst.idle_ready", {31'd0, in_ready}, 32'd1);

        run_pair("t8_post_rst", 32'h3F800000, 32'h00400000, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
